dmem_arbiter: RTL and testbench

Shares the single unregistered data RAM (combinational read, write on `CLK` rising edge) between the single-cycle core's data port and an external DMA/debug requester, e.g. a program/data loader or memory dump. The core has priority. The DMA gets idle slots immediately, and is forced in after `MAX_WAIT` contended cycles by stalling the core. The block sits between `single_cycle` and `ram_unregistered` at top level.

---
 rtl/dmem_arb_pkg.sv | 6 +
 rtl/dmem_port_mux.sv | 21 ++
 rtl/dmem_arbiter.sv | 83 ++++++++
 tb/tb_dmem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state type and RW encoding for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic {ARB_CORE, ARB_DMA} arb_state_t;
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
endpackage

// File: rtl/dmem_port_mux.sv
// dmem_port_mux: combinational 2:1 steering of the RAM port with write suppression.
module dmem_port_mux #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel_dma_i,
  input  logic                  wr_suppress_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic                  core_we_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  input  logic [ADDR_WIDTH-1:0] dma_addr_i,
  input  logic                  dma_we_i,
  input  logic [DATA_WIDTH-1:0] dma_wdata_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_rw_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o
);
  assign ram_addr_o  = sel_dma_i ? dma_addr_i : core_addr_i;
  assign ram_wdata_o = sel_dma_i ? dma_wdata_i : core_wdata_i;
  assign ram_rw_o    = !wr_suppress_i && (sel_dma_i ? dma_we_i : core_we_i);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the core (priority) and a DMA/debug port,
// forcing the DMA in after MAX_WAIT contended cycles for up to BURST_MAX locked beats.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  core_req,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic                  core_rw,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  dma_valid,
  input  logic                  dma_lock,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic                  dma_rw,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ready,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rw,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t    state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          sel_dma;
  // With dma_valid low, ARB_DMA degenerates to core ownership for that cycle.
  assign sel_dma    = dma_valid && (state_q == ARB_DMA || !core_req);
  assign dma_ready  = sel_dma && RESET_N;
  assign core_stall = state_q == ARB_DMA && dma_valid && core_req;
  assign core_rdata = ram_rdata;
  assign dma_rdata  = ram_rdata;
  dmem_port_mux #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mux (
    .sel_dma_i    (sel_dma),
    .wr_suppress_i(!RESET_N),
    .core_addr_i  (core_addr),
    .core_we_i    (core_req && (core_rw == MEM_WRITE)),
    .core_wdata_i (core_wdata),
    .dma_addr_i   (dma_addr),
    .dma_we_i     (dma_valid && (dma_rw != MEM_READ)),
    .dma_wdata_i  (dma_wdata),
    .ram_addr_o   (ram_addr),
    .ram_rw_o     (ram_rw),
    .ram_wdata_o  (ram_wdata)
  );
  always_comb begin
    state_d    = ARB_CORE;
    wait_cnt_d = '0;
    beat_cnt_d = beat_cnt_q;
    if (state_q == ARB_DMA && dma_valid) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      state_d    = (dma_lock && beat_cnt_q < BW'(BURST_MAX - 1)) ? ARB_DMA : ARB_CORE;
    end else if (state_q == ARB_CORE && core_req && dma_valid) begin
      if (wait_cnt_q == WW'(MAX_WAIT - 1)) begin
        state_d    = ARB_DMA;
        beat_cnt_d = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ARB_CORE;
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a behavioural unregistered RAM.
module tb_dmem_arbiter;
  logic        CLK, RESET_N;
  logic        core_req, core_rw, core_stall;
  logic [9:0]  core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        dma_valid, dma_lock, dma_rw, dma_ready;
  logic [9:0]  dma_addr;
  logic [31:0] dma_wdata, dma_rdata;
  logic [9:0]  ram_addr;
  logic        ram_rw;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] mem [0:1023];
  logic        clr;
  int          n_chk, n_pass, k;
  logic        exp_rdy;

  dmem_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .core_req(core_req), .core_addr(core_addr), .core_rw(core_rw), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_valid(dma_valid), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_rw(dma_rw),
    .dma_wdata(dma_wdata), .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign ram_rdata = mem[ram_addr];
  always @(posedge CLK) begin
    if (clr) for (int i = 0; i < 1024; i++) mem[i] <= '0;
    else if (ram_rw) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic drv_core(input logic req, input logic rw, input logic [9:0] a, input logic [31:0] d);
    core_req = req; core_rw = rw; core_addr = a; core_wdata = d;
  endtask

  task automatic drv_dma(input logic v, input logic lk, input logic rw, input logic [9:0] a, input logic [31:0] d);
    dma_valid = v; dma_lock = lk; dma_rw = rw; dma_addr = a; dma_wdata = d;
  endtask

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; clr = 1'b1; RESET_N = 1'b0;
    drv_core(1, 1, 10'd5, 32'hDEADBEEF);
    drv_dma(0, 0, 0, 10'd0, 32'd0);
    @(negedge CLK);
    clr = 1'b0;
    chk("rst_ram_rw", ram_rw, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_ready", dma_ready, 0);
    chk("rst_addr", ram_addr, 5);
    chk("rst_wdata", ram_wdata, 32'hDEADBEEF);
    drv_core(0, 0, 10'd5, 32'd0);
    drv_dma(1, 0, 1, 10'd7, 32'h77);
    #1;
    chk("rst_dma_ready", dma_ready, 0);
    chk("rst_dma_rw", ram_rw, 0);
    // release and core store / load
    nxt;
    RESET_N = 1'b1;
    drv_dma(0, 0, 0, 10'd0, 32'd0);
    drv_core(1, 1, 10'd5, 32'hDEADBEEF);
    @(negedge CLK);
    chk("core_wr_rw", ram_rw, 1);
    chk("core_wr_stall", core_stall, 0);
    chk("core_wr_ready", dma_ready, 0);
    nxt;
    drv_core(1, 0, 10'd5, 32'd0);
    @(negedge CLK);
    chk("core_rd5", core_rdata, 32'hDEADBEEF);
    chk("rst_no_write", mem[7], 0);
    // idle-slot steal
    nxt;
    drv_core(0, 0, 10'h3FF, 32'd0);
    drv_dma(1, 0, 1, 10'h3FF, 32'h12345678);
    @(negedge CLK);
    chk("steal_ready", dma_ready, 1);
    chk("steal_stall", core_stall, 0);
    chk("steal_rw", ram_rw, 1);
    chk("steal_addr", ram_addr, 10'h3FF);
    nxt;
    drv_dma(0, 0, 0, 10'd0, 32'd0);
    drv_core(1, 0, 10'h3FF, 32'd0);
    @(negedge CLK);
    chk("steal_rdback", core_rdata, 32'h12345678);
    chk("steal_stall2", core_stall, 0);
    nxt;
    drv_core(0, 0, 10'd0, 32'd0);
    drv_dma(1, 0, 0, 10'd5, 32'd0);
    @(negedge CLK);
    chk("steal_rd_ready", dma_ready, 1);
    chk("steal_rd_data", dma_rdata, 32'hDEADBEEF);
    // starvation: forced grant in cycle MAX_WAIT
    for (int c = 0; c < 5; c++) begin
      nxt;
      drv_core(1, 1, 10'h100 + 10'(c), 32'hC0DE0000 + 32'(c));
      drv_dma(1, 0, 1, 10'h200, 32'hAAAA0000);
      @(negedge CLK);
      chk("starve_ready", dma_ready, c == 4);
      chk("starve_stall", core_stall, c == 4);
    end
    nxt;
    drv_dma(0, 0, 0, 10'd0, 32'd0);
    drv_core(1, 0, 10'h200, 32'd0);
    @(negedge CLK);
    chk("starve_dma_data", core_rdata, 32'hAAAA0000);
    chk("starve_after_stall", core_stall, 0);
    chk("starve_c3_store", mem[10'h103], 32'hC0DE0003);
    chk("starve_c4_blocked", mem[10'h104], 0);
    // locked burst of 10 words: 8 forced, then 4 contended cycles, then 2 more
    k = 0;
    for (int c = 0; c < 18; c++) begin
      nxt;
      drv_core(1, 0, 10'h300, 32'd0);
      drv_dma(k < 10, 1, 1, 10'(k), 32'hB0000000 + 32'(k));
      @(negedge CLK);
      exp_rdy = (c >= 4 && c <= 11) || c == 16 || c == 17;
      chk("burst_ready", dma_ready, exp_rdy);
      chk("burst_stall", core_stall, exp_rdy);
      if (dma_ready) k++;
    end
    chk("burst_beats", k, 10);
    // drop valid while in ARB_DMA
    nxt;
    drv_dma(0, 1, 1, 10'd0, 32'd0);
    drv_core(1, 1, 10'h301, 32'h5555);
    @(negedge CLK);
    chk("drop_stall", core_stall, 0);
    chk("drop_ready", dma_ready, 0);
    chk("drop_rw", ram_rw, 1);
    chk("drop_addr", ram_addr, 10'h301);
    nxt;
    drv_core(1, 0, 10'h301, 32'd0);
    drv_dma(1, 1, 0, 10'd0, 32'd0);
    @(negedge CLK);
    chk("drop_back_core", dma_ready, 0);
    chk("drop_core_data", core_rdata, 32'h5555);
    for (int i = 0; i < 10; i++) chk("burst_word", mem[i], 32'hB0000000 + 32'(i));
    nxt;
    drv_core(0, 0, 10'd0, 32'd0);
    drv_dma(1, 0, 0, 10'd0, 32'd0);
    @(negedge CLK);
    chk("idle_rd_word0", dma_rdata, 32'hB0000000);
    // reset in beat 3 of a forced burst
    k = 0;
    for (int c = 0; c < 7; c++) begin
      nxt;
      drv_core(1, 0, 10'h300, 32'd0);
      drv_dma(1, 1, 1, 10'h20 + 10'(k), 32'hE0 + 32'(k));
      @(negedge CLK);
      chk("mrst_ready", dma_ready, c >= 4);
      if (dma_ready) k++;
    end
    nxt;
    drv_dma(1, 1, 1, 10'h20 + 10'(k), 32'hE0 + 32'(k));
    #1;
    chk("mrst_beat3_ready", dma_ready, 1);
    chk("mrst_beat3_stall", core_stall, 1);
    RESET_N = 1'b0;
    #1;
    chk("mrst_stall", core_stall, 0);
    chk("mrst_ready0", dma_ready, 0);
    chk("mrst_rw", ram_rw, 0);
    nxt;
    drv_dma(0, 0, 0, 10'd0, 32'd0);
    @(negedge CLK);
    chk("mrst_b0", mem[10'h20], 32'hE0);
    chk("mrst_b1", mem[10'h21], 32'hE1);
    chk("mrst_b2", mem[10'h22], 32'hE2);
    chk("mrst_b3_lost", mem[10'h23], 0);
    nxt;
    RESET_N = 1'b1;
    drv_core(1, 0, 10'h300, 32'd0);
    drv_dma(1, 1, 1, 10'h23, 32'hE3);
    @(negedge CLK);
    chk("mrst_core_state", dma_ready, 0);
    chk("mrst_core_nostall", core_stall, 0);
    nxt;
    drv_dma(0, 0, 0, 10'd0, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
